// File: rtl/address_offset_module_pkg.sv
// Shared definitions for the per-thread address offset block:
// config word layout and thread-ID sizing.
package address_offset_module_pkg;

  typedef enum logic [2:0] {
    CFG_OFF_A = 3'd0,
    CFG_OFF_B = 3'd1,
    CFG_OFF_D = 3'd2,
    CFG_INC_A = 3'd3,
    CFG_INC_B = 3'd4,
    CFG_INC_D = 3'd5
  } cfg_word_e;

  localparam int CFG_WORD_COUNT = 6;

  function automatic int thread_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/address_offset_module_operand.sv
// One operand's per-thread offset/increment tables, shared-range decode,
// registered offset adder, and commit-increment vs config-write arbitration.
module aom_operand
  import address_offset_module_pkg::*;
#(
  parameter int ADDR_WIDTH        = 10,
  parameter int INC_WIDTH         = 4,
  parameter int WORD_WIDTH        = 36,
  parameter int THREAD_COUNT      = 8,
  parameter int SHARED_ADDR_BASE  = 1,
  parameter int SHARED_ADDR_COUNT = 4,
  parameter int THREAD_WIDTH      = thread_width(THREAD_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [THREAD_WIDTH-1:0] issue_thread,
  input  logic                    commit_en,
  input  logic [THREAD_WIDTH-1:0] commit_thread,
  input  logic                    cfg_off_en,
  input  logic                    cfg_inc_en,
  input  logic [THREAD_WIDTH-1:0] cfg_thread,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  output logic [ADDR_WIDTH-1:0]   addr_offset,
  output logic                    shared
);

  logic [ADDR_WIDTH-1:0] offset_reg [THREAD_COUNT];
  logic [INC_WIDTH-1:0]  inc_reg    [THREAD_COUNT];
  logic [ADDR_WIDTH-1:0] inc_ext    [THREAD_COUNT];
  logic [31:0]           addr_ext;
  logic                  shared_next;
  logic [ADDR_WIDTH-1:0] addr_offset_next;
  logic                  unused_cfg_bits;

  assign addr_ext    = 32'(addr);
  assign shared_next = (addr_ext >= 32'(SHARED_ADDR_BASE)) &&
                       (addr_ext <  32'(SHARED_ADDR_BASE + SHARED_ADDR_COUNT));
  assign addr_offset_next = shared_next ? addr + offset_reg[issue_thread] : addr;
  assign unused_cfg_bits  = ^cfg_data[WORD_WIDTH-1:ADDR_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < THREAD_COUNT; gi++) begin : g_inc_ext
      assign inc_ext[gi] = {{(ADDR_WIDTH-INC_WIDTH){inc_reg[gi][INC_WIDTH-1]}}, inc_reg[gi]};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_offset <= '0;
      shared      <= 1'b0;
    end else begin
      addr_offset <= addr_offset_next;
      shared      <= shared_next;
    end
  end

  // A config write to the same offset entry overrides a simultaneous increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < THREAD_COUNT; t++) begin
        offset_reg[t] <= '0;
        inc_reg[t]    <= '0;
      end
    end else begin
      for (int t = 0; t < THREAD_COUNT; t++) begin
        if (cfg_off_en && cfg_thread == THREAD_WIDTH'(t))
          offset_reg[t] <= cfg_data[ADDR_WIDTH-1:0];
        else if (commit_en && commit_thread == THREAD_WIDTH'(t))
          offset_reg[t] <= offset_reg[t] + inc_ext[t];
        if (cfg_inc_en && cfg_thread == THREAD_WIDTH'(t))
          inc_reg[t] <= cfg_data[INC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/address_offset_module.sv
// Per-thread indirect addressing ahead of the Datapath: adds per-thread offsets to
// shared-range A/B/D addresses and post-increments them on committed instructions.
module address_offset_module
  import address_offset_module_pkg::*;
#(
  parameter int READ_ADDR_WIDTH   = 10,
  parameter int WRITE_ADDR_WIDTH  = 12,
  parameter int WORD_WIDTH        = 36,
  parameter int THREAD_COUNT      = 8,
  parameter int SHARED_ADDR_BASE  = 1,
  parameter int SHARED_ADDR_COUNT = 4,
  parameter int CFG_BASE_ADDR     = 1024,
  parameter int INC_WIDTH         = 4,
  parameter int COMMIT_LATENCY    = 2,
  parameter int WRITE_LATENCY     = 8,
  localparam int THREAD_WIDTH     = thread_width(THREAD_COUNT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [READ_ADDR_WIDTH-1:0]  read_addr_A,
  input  logic [READ_ADDR_WIDTH-1:0]  read_addr_B,
  input  logic [WRITE_ADDR_WIDTH-1:0] write_addr_D,
  input  logic                        IO_ready,
  input  logic                        branch_cancel,
  input  logic [WRITE_ADDR_WIDTH-1:0] write_addr_Ra,
  input  logic [WORD_WIDTH-1:0]       Ra,
  output logic [READ_ADDR_WIDTH-1:0]  read_addr_A_offset,
  output logic [READ_ADDR_WIDTH-1:0]  read_addr_B_offset,
  output logic [WRITE_ADDR_WIDTH-1:0] write_addr_D_offset,
  output logic [THREAD_WIDTH-1:0]     thread
);

  logic [THREAD_WIDTH-1:0] thread_cnt_reg;
  logic [THREAD_WIDTH+2:0] commit_dl_reg [COMMIT_LATENCY];
  logic [THREAD_WIDTH-1:0] wthread_dl_reg [WRITE_LATENCY];
  logic                    shared_a, shared_b, shared_d;
  logic [THREAD_WIDTH-1:0] commit_thread;
  logic                    commit_sh_a, commit_sh_b, commit_sh_d;
  logic                    commit_ok;
  logic [THREAD_WIDTH-1:0] cfg_thread;
  logic [31:0]             ra_addr_ext;
  logic [31:0]             cfg_index;
  logic                    cfg_hit;
  logic [CFG_WORD_COUNT-1:0] cfg_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      thread_cnt_reg <= '0;
      thread         <= '0;
    end else begin
      thread_cnt_reg <= (thread_cnt_reg == THREAD_WIDTH'(THREAD_COUNT - 1)) ?
                        '0 : thread_cnt_reg + THREAD_WIDTH'(1);
      thread         <= thread_cnt_reg;
    end
  end

  // Output-stage tags travel down these lines to meet their commit flags / writebacks.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < COMMIT_LATENCY; i++) commit_dl_reg[i]  <= '0;
      for (int i = 0; i < WRITE_LATENCY; i++)  wthread_dl_reg[i] <= '0;
    end else begin
      commit_dl_reg[0]  <= {thread, shared_d, shared_b, shared_a};
      wthread_dl_reg[0] <= thread;
      for (int i = 1; i < COMMIT_LATENCY; i++) commit_dl_reg[i]  <= commit_dl_reg[i-1];
      for (int i = 1; i < WRITE_LATENCY; i++)  wthread_dl_reg[i] <= wthread_dl_reg[i-1];
    end
  end

  assign {commit_thread, commit_sh_d, commit_sh_b, commit_sh_a} = commit_dl_reg[COMMIT_LATENCY-1];
  assign commit_ok  = IO_ready & ~branch_cancel;
  assign cfg_thread = wthread_dl_reg[WRITE_LATENCY-1];

  assign ra_addr_ext = 32'(write_addr_Ra);
  assign cfg_index   = ra_addr_ext - 32'(CFG_BASE_ADDR);
  assign cfg_hit     = (ra_addr_ext >= 32'(CFG_BASE_ADDR)) && (cfg_index < 32'(CFG_WORD_COUNT));

  genvar gi;
  generate
    for (gi = 0; gi < CFG_WORD_COUNT; gi++) begin : g_cfg_decode
      assign cfg_en[gi] = cfg_hit && (cfg_index == 32'(gi));
    end
  endgenerate

  aom_operand #(
    .ADDR_WIDTH(READ_ADDR_WIDTH), .INC_WIDTH(INC_WIDTH), .WORD_WIDTH(WORD_WIDTH),
    .THREAD_COUNT(THREAD_COUNT), .SHARED_ADDR_BASE(SHARED_ADDR_BASE),
    .SHARED_ADDR_COUNT(SHARED_ADDR_COUNT), .THREAD_WIDTH(THREAD_WIDTH)
  ) u_operand_a (
    .clock(clock), .reset(reset), .addr(read_addr_A), .issue_thread(thread_cnt_reg),
    .commit_en(commit_ok & commit_sh_a), .commit_thread(commit_thread),
    .cfg_off_en(cfg_en[CFG_OFF_A]), .cfg_inc_en(cfg_en[CFG_INC_A]),
    .cfg_thread(cfg_thread), .cfg_data(Ra),
    .addr_offset(read_addr_A_offset), .shared(shared_a)
  );

  aom_operand #(
    .ADDR_WIDTH(READ_ADDR_WIDTH), .INC_WIDTH(INC_WIDTH), .WORD_WIDTH(WORD_WIDTH),
    .THREAD_COUNT(THREAD_COUNT), .SHARED_ADDR_BASE(SHARED_ADDR_BASE),
    .SHARED_ADDR_COUNT(SHARED_ADDR_COUNT), .THREAD_WIDTH(THREAD_WIDTH)
  ) u_operand_b (
    .clock(clock), .reset(reset), .addr(read_addr_B), .issue_thread(thread_cnt_reg),
    .commit_en(commit_ok & commit_sh_b), .commit_thread(commit_thread),
    .cfg_off_en(cfg_en[CFG_OFF_B]), .cfg_inc_en(cfg_en[CFG_INC_B]),
    .cfg_thread(cfg_thread), .cfg_data(Ra),
    .addr_offset(read_addr_B_offset), .shared(shared_b)
  );

  aom_operand #(
    .ADDR_WIDTH(WRITE_ADDR_WIDTH), .INC_WIDTH(INC_WIDTH), .WORD_WIDTH(WORD_WIDTH),
    .THREAD_COUNT(THREAD_COUNT), .SHARED_ADDR_BASE(SHARED_ADDR_BASE),
    .SHARED_ADDR_COUNT(SHARED_ADDR_COUNT), .THREAD_WIDTH(THREAD_WIDTH)
  ) u_operand_d (
    .clock(clock), .reset(reset), .addr(write_addr_D), .issue_thread(thread_cnt_reg),
    .commit_en(commit_ok & commit_sh_d), .commit_thread(commit_thread),
    .cfg_off_en(cfg_en[CFG_OFF_D]), .cfg_inc_en(cfg_en[CFG_INC_D]),
    .cfg_thread(cfg_thread), .cfg_data(Ra),
    .addr_offset(write_addr_D_offset), .shared(shared_d)
  );

endmodule

// File: tb/tb_address_offset_module.sv
// Self-checking bench: vector table, directed commit/config sequences, and random
// traffic against a per-instruction history model of offsets and increments.
module tb_address_offset_module;

  localparam int RAW  = 10;
  localparam int WAW  = 12;
  localparam int TC   = 8;
  localparam int SB   = 1;
  localparam int SC   = 4;
  localparam int CFG  = 1024;
  localparam int CL   = 2;
  // Congruent to CL modulo TC so a config write can land on its own thread's commit cycle.
  localparam int WL   = 10;
  localparam int MAXC = 4096;

  logic            clock = 1'b0;
  logic            reset;
  logic [RAW-1:0]  read_addr_A, read_addr_B;
  logic [WAW-1:0]  write_addr_D, write_addr_Ra;
  logic            IO_ready, branch_cancel;
  logic [35:0]     Ra;
  logic [RAW-1:0]  read_addr_A_offset, read_addr_B_offset;
  logic [WAW-1:0]  write_addr_D_offset;
  logic [2:0]      thread;

  always #5 clock = ~clock;

  address_offset_module #(.WRITE_LATENCY(WL)) dut (
    .clock(clock), .reset(reset),
    .read_addr_A(read_addr_A), .read_addr_B(read_addr_B), .write_addr_D(write_addr_D),
    .IO_ready(IO_ready), .branch_cancel(branch_cancel),
    .write_addr_Ra(write_addr_Ra), .Ra(Ra),
    .read_addr_A_offset(read_addr_A_offset), .read_addr_B_offset(read_addr_B_offset),
    .write_addr_D_offset(write_addr_D_offset), .thread(thread)
  );

  typedef struct {
    int a; int b; int d;
    int ea; int eb; int ed; int et;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc;
  int         off [TC][3];
  int         inc [TC][3];
  int         out_thr [MAXC];
  logic [2:0] out_sh  [MAXC];
  logic       drv_rdy = 1'b0;
  logic       drv_cancel = 1'b0;
  vec_t       vecs [6];

  function automatic int wd(input int x);
    return (x == 2) ? WAW : RAW;
  endfunction

  function automatic int wrapv(input int v, input int w);
    int m;
    m = 1 << w;
    return ((v % m) + m) % m;
  endfunction

  function automatic int sext4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic logic is_shared(input int v);
    return (v >= SB) && (v < SB + SC);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < TC; t++)
      for (int x = 0; x < 3; x++) begin
        off[t][x] = 0;
        inc[t][x] = 0;
      end
    cyc = 0;
    out_thr[0] = 0;
    out_sh[0]  = 3'b000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read_addr_A = '0; read_addr_B = '0; write_addr_D = '0;
    write_addr_Ra = '0; Ra = '0;
    IO_ready = drv_rdy; branch_cancel = drv_cancel;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("reset_A", int'(read_addr_A_offset), 0);
    check("reset_B", int'(read_addr_B_offset), 0);
    check("reset_D", int'(write_addr_D_offset), 0);
    check("reset_thread", int'(thread), 0);
    reset = 1'b0;
    model_reset();
  endtask

  // One issue cycle: model predicts outputs, then applies commit and config effects.
  task automatic step(input int a, input int b, input int d, input int wra, input logic [35:0] ra);
    int thr, m, ct, k, ea, eb, ed;
    int addr [3];
    logic [2:0] sh;
    read_addr_A = RAW'(a); read_addr_B = RAW'(b); write_addr_D = WAW'(d);
    IO_ready = drv_rdy; branch_cancel = drv_cancel;
    write_addr_Ra = WAW'(wra); Ra = ra;
    addr[0] = a; addr[1] = b; addr[2] = d;
    thr = cyc % TC;
    for (int x = 0; x < 3; x++) sh[x] = is_shared(addr[x]);
    ea = sh[0] ? wrapv(a + off[thr][0], RAW) : a;
    eb = sh[1] ? wrapv(b + off[thr][1], RAW) : b;
    ed = sh[2] ? wrapv(d + off[thr][2], WAW) : d;
    out_thr[cyc + 1] = thr;
    out_sh[cyc + 1]  = sh;
    m = cyc - CL;
    if (m >= 1 && drv_rdy && !drv_cancel)
      for (int x = 0; x < 3; x++)
        if (out_sh[m][x])
          off[out_thr[m]][x] = wrapv(off[out_thr[m]][x] + sext4(inc[out_thr[m]][x]), wd(x));
    m  = cyc - WL;
    ct = (m >= 1) ? out_thr[m] : 0;
    if (wra >= CFG && wra < CFG + 6) begin
      k = wra - CFG;
      if (k < 3) off[ct][k] = wrapv(int'(ra[11:0]), wd(k));
      else       inc[ct][k-3] = int'(ra[3:0]);
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check("A", int'(read_addr_A_offset), ea);
    check("B", int'(read_addr_B_offset), eb);
    check("D", int'(write_addr_D_offset), ed);
    check("thread", int'(thread), thr);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 36'd0);
  endtask

  task automatic cfg_write(input int t, input int k, input logic [35:0] data);
    int guard;
    guard = 0;
    while (!(cyc - WL >= 1 && out_thr[cyc - WL] == t) && guard < 4 * TC) begin
      idle();
      guard++;
    end
    if (guard >= 4 * TC) begin
      n_checks++;
      n_fail++;
      $display("FAIL cfg_slot: thread %0d slot not reached, expected within %0d cycles", t, 4 * TC);
    end else begin
      step(0, 0, 0, CFG + k, data);
    end
  endtask

  task automatic issue_a(input int t, input int a, input int exp, input logic settle);
    while (cyc % TC != t) idle();
    step(a, 0, 0, 0, 36'd0);
    check("spec_A", int'(read_addr_A_offset), exp);
    if (settle) repeat (CL + 1) idle();
  endtask

  function automatic int rand_addr(input int w);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4) return int'($urandom_range(SB, SB + SC - 1));
    if (r == 4) return 0;
    if (r == 5) return SB + SC;
    return int'($urandom_range(0, (1 << w) - 1));
  endfunction

  initial begin
    vecs[0] = '{5, 0, 7, 5, 0, 7, 0};
    vecs[1] = '{2, 3, 4, 2, 3, 4, 1};
    vecs[2] = '{0, 1023, 4095, 0, 1023, 4095, 2};
    vecs[3] = '{4, 5, 1, 4, 5, 1, 3};
    vecs[4] = '{1023, 1, 1024, 1023, 1, 1024, 4};
    vecs[5] = '{6, 4, 5, 6, 4, 5, 5};

    // Reset state and pass-through with zero offsets.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].d, 0, 36'd0);
      check("vec_A", int'(read_addr_A_offset), vecs[i].ea);
      check("vec_B", int'(read_addr_B_offset), vecs[i].eb);
      check("vec_D", int'(write_addr_D_offset), vecs[i].ed);
      check("vec_thread", int'(thread), vecs[i].et);
    end

    // Committed increment, other threads unaffected.
    drv_rdy = 1'b1; drv_cancel = 1'b0;
    do_reset();
    cfg_write(3, 0, 36'd16);
    cfg_write(3, 3, 36'd1);
    issue_a(3, 2, 18, 1'b1);
    issue_a(3, 2, 19, 1'b1);
    issue_a(4, 2, 2, 1'b1);

    // Not ready, then cancelled: offset holds.
    drv_rdy = 1'b0;
    do_reset();
    cfg_write(3, 0, 36'd16);
    cfg_write(3, 3, 36'd1);
    issue_a(3, 2, 18, 1'b1);
    issue_a(3, 2, 18, 1'b1);
    drv_rdy = 1'b1; drv_cancel = 1'b1;
    issue_a(3, 2, 18, 1'b1);
    issue_a(3, 2, 18, 1'b1);
    drv_cancel = 1'b0;

    // Wrap in both directions.
    do_reset();
    cfg_write(3, 0, 36'd1023);
    cfg_write(3, 3, 36'd1);
    issue_a(3, 1, 0, 1'b1);
    cfg_write(3, 3, 36'hF);
    issue_a(3, 1, 1, 1'b1);
    issue_a(3, 1, 0, 1'b1);

    // Config write vs increment in the same cycle: same entry and different entries.
    do_reset();
    cfg_write(3, 3, 36'd1);
    issue_a(3, 2, 2, 1'b0);
    idle(); idle();
    step(0, 0, 0, CFG + 0, 36'd40);
    issue_a(3, 2, 42, 1'b0);
    idle(); idle();
    step(0, 0, 0, CFG + 3, 36'd2);
    issue_a(3, 2, 43, 1'b1);
    issue_a(3, 2, 45, 1'b1);

    // Reset while a commit is pending.
    do_reset();
    cfg_write(3, 0, 36'd16);
    cfg_write(3, 3, 36'd1);
    issue_a(3, 2, 18, 1'b0);
    idle();
    do_reset();
    issue_a(3, 2, 2, 1'b1);
    issue_a(3, 2, 2, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 900; i++) begin
      int wra, r;
      logic [35:0] ra;
      drv_rdy    = ($urandom_range(0, 3) != 0);
      drv_cancel = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 3)       wra = CFG + int'($urandom_range(0, 5));
      else if (r == 3) wra = int'($urandom_range(0, (1 << WAW) - 1));
      else             wra = 0;
      ra = {4'($urandom_range(0, 15)), 32'($urandom)};
      step(rand_addr(RAW), rand_addr(RAW), rand_addr(WAW), wra, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
